// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - register file write-back queue with read bypass
//
// Buffers register write-back requests and drains them one per cycle onto
// the register file write port. The two read ports see the youngest queued
// (or in-flight) write to their address instead of stale register contents.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/ready       write request handshake (ready = not full)
//   req_addr, req_data    destination register and data
//   flush                 discard all queued entries (highest priority)
//   rf_hold               register file port busy, drain stalls
//   wr, dirW, datoIn      registered register file write port
//   rd_addr1/2            register file read addresses
//   rf_data1/2            raw register file read data
//   byp_data1/2           read data with queued writes forwarded
//   count                 current occupancy
//   overflow              sticky, request seen while full
module wb_write_queue #(
    parameter int DEPTH        = 4,
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int ZERO_DISCARD = 0,
    localparam int PW          = $clog2(DEPTH),
    localparam int CW          = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    input  logic          flush,
    input  logic          rf_hold,
    output logic          wr,
    output logic [AW-1:0] dirW,
    output logic [DW-1:0] datoIn,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    input  logic [DW-1:0] rf_data1,
    input  logic [DW-1:0] rf_data2,
    output logic [DW-1:0] byp_data1,
    output logic [DW-1:0] byp_data2,
    output logic [CW-1:0] count,
    output logic          overflow
);

    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_q, wr_d;
    logic [AW-1:0]    dirw_q, dirw_d;
    logic [DW-1:0]    datoin_q, datoin_d;
    logic             overflow_q, overflow_d;

    logic full;
    logic empty;
    logic addr_is_zero;
    logic store;
    logic drain;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign addr_is_zero = (req_addr == '0);

    // A discarded address-0 request still completes its handshake; it
    // simply never occupies a slot.
    assign store = req_valid && !full && !flush &&
                   !((ZERO_DISCARD != 0) && addr_is_zero);
    assign drain = !empty && !rf_hold && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        wr_d       = 1'b0;
        dirw_d     = dirw_q;
        datoin_d   = datoin_q;
        overflow_d = overflow_q | (req_valid & full);

        if (flush) begin
            valid_d  = '0;
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (drain) begin
                wr_d              = 1'b1;
                dirw_d            = addr_q[rd_ptr_q];
                datoin_d          = data_q[rd_ptr_q];
                valid_d[rd_ptr_q] = 1'b0;
                rd_ptr_d          = rd_ptr_q + 1'b1;
            end
            // rd and wr pointers only coincide when empty or full, so a
            // simultaneous store and drain never touch the same slot.
            if (store) begin
                valid_d[wr_ptr_q] = 1'b1;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(store) - CW'(drain);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            valid_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wr_q       <= 1'b0;
            dirw_q     <= '0;
            datoin_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (store) begin
                addr_q[wr_ptr_q] <= req_addr;
                data_q[wr_ptr_q] <= req_data;
            end
            valid_q    <= valid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            dirw_q     <= dirw_d;
            datoin_q   <= datoin_d;
            overflow_q <= overflow_d;
        end
    end

    // Bypass search runs oldest to youngest so later matches override
    // earlier ones. The in-flight write is the oldest candidate: the
    // register file only holds its value from the following cycle on.
    always_comb begin
        byp_data1 = rf_data1;
        byp_data2 = rf_data2;
        if (wr_q && (dirw_q == rd_addr1)) byp_data1 = datoin_q;
        if (wr_q && (dirw_q == rd_addr2)) byp_data2 = datoin_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[rd_ptr_q + PW'(i)] && (addr_q[rd_ptr_q + PW'(i)] == rd_addr1))
                byp_data1 = data_q[rd_ptr_q + PW'(i)];
            if (valid_q[rd_ptr_q + PW'(i)] && (addr_q[rd_ptr_q + PW'(i)] == rd_addr2))
                byp_data2 = data_q[rd_ptr_q + PW'(i)];
        end
        if ((ZERO_DISCARD != 0) && (rd_addr1 == '0)) byp_data1 = rf_data1;
        if ((ZERO_DISCARD != 0) && (rd_addr2 == '0)) byp_data2 = rf_data2;
    end

    assign req_ready = !full;
    assign wr        = wr_q;
    assign dirW      = dirw_q;
    assign datoIn    = datoin_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - directed self-checking bench for wb_write_queue
module tb_wb_write_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic        flush;
    logic        rf_hold;
    logic [4:0]  rd_addr1, rd_addr2;
    logic [31:0] rf_data1, rf_data2;

    logic        req_ready, wr, overflow;
    logic [4:0]  dirW;
    logic [31:0] datoIn, byp_data1, byp_data2;
    logic [2:0]  count;

    logic        req_ready_z, wr_z, overflow_z;
    logic [4:0]  dirW_z;
    logic [31:0] datoIn_z, byp_data1_z, byp_data2_z;
    logic [2:0]  count_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(4), .AW(5), .DW(32), .ZERO_DISCARD(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .flush(flush), .rf_hold(rf_hold),
        .wr(wr), .dirW(dirW), .datoIn(datoIn), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .byp_data1(byp_data1),
        .byp_data2(byp_data2), .count(count), .overflow(overflow)
    );

    wb_write_queue #(.DEPTH(4), .AW(5), .DW(32), .ZERO_DISCARD(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_z),
        .req_addr(req_addr), .req_data(req_data), .flush(flush), .rf_hold(rf_hold),
        .wr(wr_z), .dirW(dirW_z), .datoIn(datoIn_z), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .byp_data1(byp_data1_z),
        .byp_data2(byp_data2_z), .count(count_z), .overflow(overflow_z)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_addr = 0; req_data = 0; flush = 0; rf_hold = 0;
        rd_addr1 = 5'd3; rd_addr2 = 5'd4; rf_data1 = 32'hAAAA_0001; rf_data2 = 32'hBBBB_0002;
        #2;
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (wr !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", wr); end
        total++; if (dirW !== 5'd0 || datoIn !== 32'd0) begin bad++; $display("FAIL reset_port got=%0d/%h exp=0/0", dirW, datoIn); end
        total++; if (overflow !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL reset_flags got ovf=%b rdy=%b exp 0/1", overflow, req_ready); end
        total++; if (byp_data1 !== 32'hAAAA_0001 || byp_data2 !== 32'hBBBB_0002) begin bad++; $display("FAIL reset_bypass got=%h/%h exp=aaaa0001/bbbb0002", byp_data1, byp_data2); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_valid = 1; req_addr = 5'd5; req_data = 32'h11;
        rd_addr1 = 5'd5; rf_data1 = 32'd0;
        step();
        req_valid = 0;
        total++; if (count !== 3'd1 || wr !== 1'b0) begin bad++; $display("FAIL single_accept got cnt=%0d wr=%b exp 1/0", count, wr); end
        total++; if (byp_data1 !== 32'h11) begin bad++; $display("FAIL single_byp_queued got=%h exp=11", byp_data1); end
        step();
        total++; if (wr !== 1'b1 || dirW !== 5'd5 || datoIn !== 32'h11) begin bad++; $display("FAIL single_drain got wr=%b dir=%0d dat=%h exp 1/5/11", wr, dirW, datoIn); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL single_count got=%0d exp=0", count); end
        total++; if (byp_data1 !== 32'h11) begin bad++; $display("FAIL single_byp_inflight got=%h exp=11", byp_data1); end
        step();
        total++; if (wr !== 1'b0 || byp_data1 !== 32'd0) begin bad++; $display("FAIL single_after got wr=%b byp=%h exp 0/0", wr, byp_data1); end
    endtask

    task automatic test_overflow();
        rf_hold = 1;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1; req_addr = 5'(i); req_data = 32'(i * 10);
            step();
        end
        req_valid = 0;
        total++; if (count !== 3'd4 || req_ready !== 1'b0) begin bad++; $display("FAIL full_state got cnt=%0d rdy=%b exp 4/0", count, req_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow); end
        req_valid = 1; req_addr = 5'd9; req_data = 32'd90;
        step();
        req_valid = 0;
        total++; if (overflow !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL ovf_set got ovf=%b cnt=%0d exp 1/4", overflow, count); end
        rf_hold = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            total++;
            if (wr !== 1'b1 || dirW !== 5'(i) || datoIn !== 32'(i * 10)) begin
                bad++; $display("FAIL drain_order_%0d got wr=%b dir=%0d dat=%0d exp 1/%0d/%0d", i, wr, dirW, datoIn, i, i * 10);
            end
        end
        step();
        total++; if (wr !== 1'b0 || count !== 3'd0 || overflow !== 1'b1) begin bad++; $display("FAIL drain_end got wr=%b cnt=%0d ovf=%b exp 0/0/1", wr, count, overflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            req_valid = 1; req_addr = 5'(20 + i); req_data = 32'(500 + i);
            step();
            if (i > 0) begin
                total++;
                if (count !== 3'd1 || wr !== 1'b1 || dirW !== 5'(19 + i)) begin
                    bad++; $display("FAIL b2b_%0d got cnt=%0d wr=%b dir=%0d exp 1/1/%0d", i, count, wr, dirW, 19 + i);
                end
            end
        end
        req_valid = 0;
        step();
        total++; if (count !== 3'd0 || wr !== 1'b1 || dirW !== 5'd22 || datoIn !== 32'd502) begin bad++; $display("FAIL b2b_last got cnt=%0d wr=%b dir=%0d dat=%0d exp 0/1/22/502", count, wr, dirW, datoIn); end
        step();
    endtask

    task automatic test_bypass_flush();
        rf_hold = 1;
        rd_addr1 = 5'd7; rf_data1 = 32'd45;
        rd_addr2 = 5'd8; rf_data2 = 32'd132;
        req_valid = 1; req_addr = 5'd7; req_data = 32'd100; step();
        req_addr = 5'd7; req_data = 32'd200; step();
        req_valid = 0;
        total++; if (byp_data1 !== 32'd200) begin bad++; $display("FAIL byp_youngest got=%0d exp=200", byp_data1); end
        total++; if (byp_data2 !== 32'd132) begin bad++; $display("FAIL byp_nomatch got=%0d exp=132", byp_data2); end
        req_valid = 1; req_addr = 5'd1; req_data = 32'd1; step();
        req_addr = 5'd2; req_data = 32'd2; step();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL prefill got=%0d exp=4", count); end
        req_addr = 5'd3; req_data = 32'd3; flush = 1;
        step();
        flush = 0; req_valid = 0;
        total++; if (count !== 3'd0 || wr !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL flush_state got cnt=%0d wr=%b rdy=%b exp 0/0/1", count, wr, req_ready); end
        total++; if (byp_data1 !== 32'd45 || byp_data2 !== 32'd132) begin bad++; $display("FAIL flush_byp got=%0d/%0d exp=45/132", byp_data1, byp_data2); end
        rf_hold = 0;
        step();
        total++; if (wr !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL flush_nodrain got wr=%b cnt=%0d exp 0/0", wr, count); end
    endtask

    task automatic test_zero_discard();
        do_reset();
        rd_addr1 = 5'd0; rf_data1 = 32'd77;
        req_valid = 1; req_addr = 5'd0; req_data = 32'd99;
        #1;
        total++; if (req_ready_z !== 1'b1) begin bad++; $display("FAIL zd_ready got=%b exp=1", req_ready_z); end
        step();
        req_valid = 0;
        total++; if (count_z !== 3'd0) begin bad++; $display("FAIL zd_count got=%0d exp=0", count_z); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL nz_count got=%0d exp=1", count); end
        total++; if (byp_data1_z !== 32'd77) begin bad++; $display("FAIL zd_byp got=%0d exp=77", byp_data1_z); end
        total++; if (byp_data1 !== 32'd99) begin bad++; $display("FAIL nz_byp got=%0d exp=99", byp_data1); end
        step();
        total++; if (wr_z !== 1'b0) begin bad++; $display("FAIL zd_nowr got=%b exp=0", wr_z); end
        total++; if (wr !== 1'b1 || dirW !== 5'd0 || datoIn !== 32'd99) begin bad++; $display("FAIL nz_wr got wr=%b dir=%0d dat=%0d exp 1/0/99", wr, dirW, datoIn); end
        step();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        rf_hold = 1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1; req_addr = 5'(10 + i); req_data = 32'(1000 + i);
            step();
        end
        req_valid = 0; rf_hold = 0;
        step();
        total++; if (count !== 3'd3 || wr !== 1'b1 || dirW !== 5'd10) begin bad++; $display("FAIL pre_reset got cnt=%0d wr=%b dir=%0d exp 3/1/10", count, wr, dirW); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (wr !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL async_reset got wr=%b cnt=%0d exp 0/0", wr, count); end
        step();
        rst_n = 1'b1;
        step();
        total++; if (wr !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL post_reset got wr=%b cnt=%0d exp 0/0", wr, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_bypass_flush();
        test_zero_discard();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
